// File: rtl/status_logic.sv
// ----------------------------------------------------------------------------
// status_logic
//   Status side of a FIFO. Predicts the pointer values that the pointer block
//   registers on this edge and derives every status output from the predicted
//   level, so the flags registered here line up with the pointer registers
//   with zero cycles of lag.
//
// Parameters
//   POINTER_SIZE  address bits; depth = 2**POINTER_SIZE, pointers are +1 bit
//   AF_LEVEL      fifo_almost_full when level >= AF_LEVEL (AF_LEVEL <= depth)
//   AE_LEVEL      fifo_almost_empty when level <= AE_LEVEL (AE_LEVEL < AF_LEVEL)
//
// Ports
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   wr, rd               raw requests, used only to detect overflow/underflow
//   fifo_wr, fifo_rd     gated strobes from the pointer block
//   wptr, rptr           pointers, MSB is the wrap bit
//   err_clr              clears the sticky error flags
//   fifo_full/empty      level == depth / level == 0
//   fifo_almost_full/empty  threshold flags
//   fifo_level           entries held, 0..depth
//   fifo_overflow        sticky: write requested while full
//   fifo_underflow       sticky: read requested while empty
//   fifo_peak            (FIFO_PEAK_LEVEL_EN only) highest level since reset
//                        or err_clr
//
// Build option
//   FIFO_PEAK_LEVEL_EN   define to add the fifo_peak output and its register
// ----------------------------------------------------------------------------
module status_logic #(
    parameter int unsigned POINTER_SIZE = 4,
    parameter int unsigned AF_LEVEL     = 14,
    parameter int unsigned AE_LEVEL     = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr,
    input  logic                  rd,
    input  logic                  fifo_wr,
    input  logic                  fifo_rd,
    input  logic [POINTER_SIZE:0] wptr,
    input  logic [POINTER_SIZE:0] rptr,
    input  logic                  err_clr,
    output logic                  fifo_full,
    output logic                  fifo_empty,
    output logic                  fifo_almost_full,
    output logic                  fifo_almost_empty,
    output logic [POINTER_SIZE:0] fifo_level,
    output logic                  fifo_overflow,
`ifdef FIFO_PEAK_LEVEL_EN
    output logic [POINTER_SIZE:0] fifo_peak,
`endif
    output logic                  fifo_underflow
);

    localparam int unsigned PTR_W = POINTER_SIZE + 1;
    localparam int unsigned IDX_W = POINTER_SIZE;

    // Predicted pointers and level after this edge
    logic [PTR_W-1:0] nw;
    logic [PTR_W-1:0] nr;
    logic [PTR_W-1:0] nlev;

    logic             full_d,  full_q;
    logic             empty_d, empty_q;
    logic             af_d,    af_q;
    logic             ae_d,    ae_q;
    logic [PTR_W-1:0] level_d, level_q;
    logic             ovf_d,   ovf_q;
    logic             unf_d,   unf_q;
`ifdef FIFO_PEAK_LEVEL_EN
    logic [PTR_W-1:0] peak_d,  peak_q;
`endif

    // Pointer prediction mirrors the pointer block: write wins when both strobe
    always_comb begin
        nw   = wptr + PTR_W'(fifo_wr);
        nr   = rptr + PTR_W'(fifo_rd & ~fifo_wr);
        nlev = nw - nr;
    end

    // Next-state status, all derived from the predicted pointers/level
    always_comb begin
        full_d  = (nw[IDX_W] != nr[IDX_W]) && (nw[IDX_W-1:0] == nr[IDX_W-1:0]);
        empty_d = (nw == nr);
        af_d    = (nlev >= PTR_W'(AF_LEVEL));
        ae_d    = (nlev <= PTR_W'(AE_LEVEL));
        level_d = nlev;
        // A new error takes precedence over a simultaneous clear
        ovf_d   = (wr & full_q)  | (ovf_q & ~err_clr);
        unf_d   = (rd & empty_q) | (unf_q & ~err_clr);
    end

`ifdef FIFO_PEAK_LEVEL_EN
    // Peak tracks the running maximum; err_clr restarts it from the current level
    always_comb begin
        peak_d = peak_q;
        if (err_clr) begin
            peak_d = nlev;
        end else if (nlev > peak_q) begin
            peak_d = nlev;
        end
    end
`endif

    // Status registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            af_q    <= 1'b0;
            ae_q    <= 1'b1;
            level_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            full_q  <= full_d;
            empty_q <= empty_d;
            af_q    <= af_d;
            ae_q    <= ae_d;
            level_q <= level_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

`ifdef FIFO_PEAK_LEVEL_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            peak_q <= '0;
        end else begin
            peak_q <= peak_d;
        end
    end

    assign fifo_peak = peak_q;
`endif

    assign fifo_full         = full_q;
    assign fifo_empty        = empty_q;
    assign fifo_almost_full  = af_q;
    assign fifo_almost_empty = ae_q;
    assign fifo_level        = level_q;
    assign fifo_overflow     = ovf_q;
    assign fifo_underflow    = unf_q;

endmodule

// File: tb/tb_status_logic.sv
// ----------------------------------------------------------------------------
// tb_status_logic
//   Drives status_logic through a behavioural pointer block and checks every
//   output against an occupancy-count model of the FIFO.
// ----------------------------------------------------------------------------
module tb_status_logic;

    localparam int P     = 4;
    localparam int DEPTH = 16;
    localparam int AF    = 14;
    localparam int AE    = 2;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         wr = 1'b0, rd = 1'b0, fifo_wr = 1'b0, fifo_rd = 1'b0;
    logic         err_clr = 1'b0;
    logic [P:0]   wptr = '0, rptr = '0;
    logic         fifo_full, fifo_empty, fifo_almost_full, fifo_almost_empty;
    logic [P:0]   fifo_level;
    logic         fifo_overflow, fifo_underflow;
`ifdef FIFO_PEAK_LEVEL_EN
    logic [P:0]   fifo_peak;
`endif

    // Reference model state: plain occupancy count and sticky flags
    int           m_level = 0;
    logic         m_ovf = 1'b0, m_unf = 1'b0;
    int           m_peak = 0;
    int           max_seen = 0;

    int           n_tests = 0;
    int           n_fail  = 0;

    status_logic #(.POINTER_SIZE(P), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .wr                (wr),
        .rd                (rd),
        .fifo_wr           (fifo_wr),
        .fifo_rd           (fifo_rd),
        .wptr              (wptr),
        .rptr              (rptr),
        .err_clr           (err_clr),
        .fifo_full         (fifo_full),
        .fifo_empty        (fifo_empty),
        .fifo_almost_full  (fifo_almost_full),
        .fifo_almost_empty (fifo_almost_empty),
        .fifo_level        (fifo_level),
        .fifo_overflow     (fifo_overflow),
`ifdef FIFO_PEAK_LEVEL_EN
        .fifo_peak         (fifo_peak),
`endif
        .fifo_underflow    (fifo_underflow)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, %0d tests run", n_tests);
        $fatal(1, "watchdog");
    end

    // {full, empty, almost_full, almost_empty, level[4:0], overflow, underflow}
    function automatic logic [10:0] exp_vec();
        logic [P:0] lv;
        lv = (P+1)'(m_level);
        return {m_level == DEPTH, m_level == 0, m_level >= AF, m_level <= AE,
                lv, m_ovf, m_unf};
    endfunction

    function automatic logic [10:0] obs_vec();
        return {fifo_full, fifo_empty, fifo_almost_full, fifo_almost_empty,
                fifo_level, fifo_overflow, fifo_underflow};
    endfunction

    // One clock of the pointer block plus the reference model update
    task automatic step(input logic w, input logic r, input logic c);
        logic fw, fr;
        fw = w && (m_level != DEPTH);
        fr = r && (m_level != 0);
        wr = w; rd = r; err_clr = c; fifo_wr = fw; fifo_rd = fr;
        @(posedge clk);
        #1;
        if (w && m_level == DEPTH) m_ovf = 1'b1;
        else if (c)                m_ovf = 1'b0;
        if (r && m_level == 0)     m_unf = 1'b1;
        else if (c)                m_unf = 1'b0;
        if (fw)      m_level = m_level + 1;
        else if (fr) m_level = m_level - 1;
        if (c)                    m_peak = m_level;
        else if (m_level > m_peak) m_peak = m_level;
        if (m_level > max_seen) max_seen = m_level;
        wptr = wptr + (P+1)'(fw);
        rptr = rptr + (P+1)'(fr & ~fw);
        wr = 1'b0; rd = 1'b0; err_clr = 1'b0; fifo_wr = 1'b0; fifo_rd = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        n_tests++;
        if (obs_vec() !== 11'b01_01_00000_00) begin
            $display("FAIL reset_state: got %b want %b", obs_vec(), 11'b01_01_00000_00);
            n_fail++;
        end
`ifdef FIFO_PEAK_LEVEL_EN
        n_tests++;
        if (fifo_peak !== '0) begin
            $display("FAIL reset_peak: got %0d want 0", fifo_peak);
            n_fail++;
        end
`endif
        rst_n = 1'b1;
        #3;
    endtask

    task automatic test_idle();
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b0, 1'b0);
            n_tests++;
            if (obs_vec() !== 11'b01_01_00000_00) begin
                $display("FAIL idle[%0d]: got %b want %b", i, obs_vec(), 11'b01_01_00000_00);
                n_fail++;
            end
        end
    endtask

    task automatic test_fill();
        for (int i = 1; i <= DEPTH; i++) begin
            step(1'b1, 1'b0, 1'b0);
            n_tests++;
            if (obs_vec() !== exp_vec() || fifo_level !== (P+1)'(i)) begin
                $display("FAIL fill[%0d]: got %b want %b", i, obs_vec(), exp_vec());
                n_fail++;
            end
        end
        n_tests++;
        if (fifo_full !== 1'b1 || fifo_almost_full !== 1'b1 || fifo_empty !== 1'b0) begin
            $display("FAIL fill_full: full=%b af=%b empty=%b want 1 1 0",
                     fifo_full, fifo_almost_full, fifo_empty);
            n_fail++;
        end
    endtask

    task automatic test_overflow();
        step(1'b1, 1'b0, 1'b0);
        n_tests++;
        if (obs_vec() !== exp_vec() || fifo_overflow !== 1'b1 || fifo_level !== 5'd16) begin
            $display("FAIL overflow_set: got %b want %b", obs_vec(), exp_vec());
            n_fail++;
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b0);
            n_tests++;
            if (obs_vec() !== exp_vec() || fifo_overflow !== 1'b1) begin
                $display("FAIL overflow_hold[%0d]: got %b want %b", i, obs_vec(), exp_vec());
                n_fail++;
            end
        end
        step(1'b0, 1'b0, 1'b1);
        n_tests++;
        if (obs_vec() !== exp_vec() || fifo_overflow !== 1'b0) begin
            $display("FAIL overflow_clr: got %b want %b", obs_vec(), exp_vec());
            n_fail++;
        end
    endtask

    task automatic test_underflow();
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b0, 1'b1, 1'b0);
            n_tests++;
            if (obs_vec() !== exp_vec()) begin
                $display("FAIL drain[%0d]: got %b want %b", i, obs_vec(), exp_vec());
                n_fail++;
            end
        end
        step(1'b0, 1'b1, 1'b0);
        n_tests++;
        if (obs_vec() !== exp_vec() || fifo_underflow !== 1'b1 || fifo_empty !== 1'b1) begin
            $display("FAIL underflow_set: got %b want %b", obs_vec(), exp_vec());
            n_fail++;
        end
        step(1'b0, 1'b1, 1'b1);
        n_tests++;
        if (obs_vec() !== exp_vec() || fifo_underflow !== 1'b1) begin
            $display("FAIL underflow_set_wins: got %b want %b", obs_vec(), exp_vec());
            n_fail++;
        end
        step(1'b0, 1'b0, 1'b1);
        n_tests++;
        if (obs_vec() !== exp_vec() || fifo_underflow !== 1'b0) begin
            $display("FAIL underflow_clr: got %b want %b", obs_vec(), exp_vec());
            n_fail++;
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, 1'b0);
            n_tests++;
            if (obs_vec() !== exp_vec() || fifo_level !== (P+1)'(6 + i)) begin
                $display("FAIL write_priority[%0d]: got %b want %b", i, obs_vec(), exp_vec());
                n_fail++;
            end
        end
        // Alternate write-only and read-only to march both pointers past the wrap
        for (int i = 0; i < 40; i++) begin
            step(i[0] == 1'b0, i[0] == 1'b1, 1'b0);
            n_tests++;
            if (obs_vec() !== exp_vec()) begin
                $display("FAIL wrap[%0d]: got %b want %b", i, obs_vec(), exp_vec());
                n_fail++;
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            logic w, r, c;
            w = ($urandom_range(0, 99) < 55);
            r = ($urandom_range(0, 99) < 50);
            c = ($urandom_range(0, 99) < 5);
            step(w, r, c);
            n_tests++;
            if (obs_vec() !== exp_vec()) begin
                $display("FAIL random[%0d]: got %b want %b", i, obs_vec(), exp_vec());
                n_fail++;
            end
`ifdef FIFO_PEAK_LEVEL_EN
            n_tests++;
            if (fifo_peak !== (P+1)'(m_peak)) begin
                $display("FAIL random_peak[%0d]: got %0d want %0d", i, fifo_peak, m_peak);
                n_fail++;
            end
`endif
        end
    endtask

    task automatic test_reset_midstream();
        int guard;
        guard = 0;
        while (m_level != 9 && guard < 40) begin
            step(m_level < 9, m_level > 9, 1'b0);
            guard++;
        end
        n_tests++;
        if (obs_vec() !== exp_vec() || fifo_level !== 5'd9) begin
            $display("FAIL reach_level9: got %b want %b (steps %0d)", obs_vec(), exp_vec(), guard);
            n_fail++;
        end
        #2;
        rst_n = 1'b0;
        #1;
        m_level = 0; m_ovf = 1'b0; m_unf = 1'b0; m_peak = 0;
        wptr = '0; rptr = '0;
        n_tests++;
        if (obs_vec() !== 11'b01_01_00000_00) begin
            $display("FAIL async_reset: got %b want %b", obs_vec(), 11'b01_01_00000_00);
            n_fail++;
        end
`ifdef FIFO_PEAK_LEVEL_EN
        n_tests++;
        if (fifo_peak !== '0) begin
            $display("FAIL async_reset_peak: got %0d want 0", fifo_peak);
            n_fail++;
        end
`endif
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        step(1'b1, 1'b0, 1'b0);
        n_tests++;
        if (obs_vec() !== exp_vec() || fifo_level !== 5'd1) begin
            $display("FAIL after_reset_write: got %b want %b", obs_vec(), exp_vec());
            n_fail++;
        end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_fill();
        n_tests++;
        if (max_seen != DEPTH) begin
            $display("FAIL fill_peak_model: got %0d want %0d", max_seen, DEPTH);
            n_fail++;
        end
        test_overflow();
        test_underflow();
        test_back_to_back();
        test_random();
        test_reset_midstream();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
